// File: rtl/four_bank_mem_pkg.sv
// rtl/four_bank_mem_pkg.sv - shared constants for the banked main-memory model
package four_bank_mem_pkg;

    localparam int NUM_BANKS         = 4;
    localparam int BANK_SEL_LSB      = 1;
    localparam int WORD_OFFSET_LSB   = 3;
    localparam int DEFAULT_BANK_BUSY = 4;
    localparam int DEFAULT_DEPTH_W   = 8;
    localparam int DEFAULT_DATA_W    = 16;
    localparam int CNT_W             = 3;

    typedef logic [1:0] bank_idx_t;

endpackage

// File: rtl/four_bank_mem_bank.sv
// rtl/four_bank_mem_bank.sv - one memory bank: storage array, registered read, busy counter
module mem_bank
    import four_bank_mem_pkg::*;
#(
    parameter int DEPTH_W   = DEFAULT_DEPTH_W,
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int BANK_BUSY = DEFAULT_BANK_BUSY
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               wr,
    input  logic [DEPTH_W-1:0] row,
    input  logic [DATA_W-1:0]  data_in,
    output logic [DATA_W-1:0]  rdata,
    output logic               busy
);

    localparam int DEPTH = 1 << DEPTH_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0]  cnt;

    // en is only asserted while cnt==0, so load and decrement never collide
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= CNT_W'(BANK_BUSY - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Simulation model: the array is cleared on reset rather than mapped to SRAM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else if (en) begin
            if (wr) begin
                mem[row] <= data_in;
            end else begin
                rdata <= mem[row];
            end
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/four_bank_mem.sv
// rtl/four_bank_mem.sv - four-way interleaved main memory with two-cycle read latency
module four_bank_mem
    import four_bank_mem_pkg::*;
#(
    parameter int DEPTH_W   = DEFAULT_DEPTH_W,
    parameter int BANK_BUSY = DEFAULT_BANK_BUSY,
    parameter int DATA_W    = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              wr,
    input  logic              rd,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              stall,
    output logic [3:0]        busy,
    output logic              err
);

    logic               req;
    logic               illegal;
    logic               accept;
    bank_idx_t          bank;
    logic [DEPTH_W-1:0] row;
    logic [NUM_BANKS-1:0] bank_en;
    logic [DATA_W-1:0]  rdata [NUM_BANKS];

    logic      rd_pend;
    bank_idx_t rd_sel;

    // High address bits alias onto the same rows by design
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[15:DEPTH_W+3];

    assign req     = rd ^ wr;
    assign bank    = addr[BANK_SEL_LSB +: 2];
    assign row     = addr[WORD_OFFSET_LSB +: DEPTH_W];
    assign illegal = (rd & wr) | (req & addr[0]);
    assign stall   = req & busy[bank] & ~illegal;
    assign accept  = req & ~busy[bank] & ~illegal;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        assign bank_en[b] = accept & (bank == bank_idx_t'(b));

        mem_bank #(
            .DEPTH_W   (DEPTH_W),
            .DATA_W    (DATA_W),
            .BANK_BUSY (BANK_BUSY)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .en      (bank_en[b]),
            .wr      (wr),
            .row     (row),
            .data_in (data_in),
            .rdata   (rdata[b]),
            .busy    (busy[b])
        );
    end

    // Second read stage: the selected bank cannot accept again next cycle, so its rdata is stable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend    <= 1'b0;
            rd_sel     <= '0;
            data_valid <= 1'b0;
            data_out   <= '0;
            err        <= 1'b0;
        end else begin
            rd_pend    <= accept & rd;
            rd_sel     <= bank;
            data_valid <= rd_pend;
            data_out   <= rd_pend ? rdata[rd_sel] : '0;
            err        <= illegal;
        end
    end

endmodule

// File: tb/tb_four_bank_mem.sv
// tb/tb_four_bank_mem.sv - table-driven self-checking bench for four_bank_mem
module tb_four_bank_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        wr;
    logic        rd;
    logic [15:0] data_out;
    logic        data_valid;
    logic        stall;
    logic [3:0]  busy;
    logic        err;

    always #5 clk = ~clk;

    four_bank_mem dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .data_in    (data_in),
        .wr         (wr),
        .rd         (rd),
        .data_out   (data_out),
        .data_valid (data_valid),
        .stall      (stall),
        .busy       (busy),
        .err        (err)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] din;
        logic        stall;
        logic        valid;
        logic [15:0] dout;
        logic [3:0]  busy;
        logic        err;
    } vec_t;

    vec_t vecs [64];
    int   nvec;
    int   checks;
    int   errors;

    task automatic add_vec(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                           input logic s, input logic v, input logic [15:0] q, input logic [3:0] b,
                           input logic e);
        vecs[nvec] = '{r, w, a, d, s, v, q, b, e};
        nvec++;
    endtask

    task automatic idle(input logic v, input logic [15:0] q, input logic [3:0] b, input logic e);
        add_vec(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, v, q, b, e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        nvec   = 0;

        // reset release then idle
        for (int i = 0; i < 5; i++) idle(0, 16'h0, 4'b0000, 0);
        // write then stalled read of the same bank
        add_vec(0, 1, 16'h0010, 16'hA5A5, 0, 0, 16'h0, 4'b0000, 0);
        add_vec(1, 0, 16'h0010, 16'h0000, 1, 0, 16'h0, 4'b0001, 0);
        add_vec(1, 0, 16'h0010, 16'h0000, 1, 0, 16'h0, 4'b0001, 0);
        add_vec(1, 0, 16'h0010, 16'h0000, 1, 0, 16'h0, 4'b0001, 0);
        add_vec(1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0, 4'b0000, 0);
        idle(0, 16'h0, 4'b0001, 0);
        idle(1, 16'hA5A5, 4'b0001, 0);
        idle(0, 16'h0, 4'b0001, 0);
        idle(0, 16'h0, 4'b0000, 0);
        // line write burst then line read burst
        add_vec(0, 1, 16'h0100, 16'h1111, 0, 0, 16'h0, 4'b0000, 0);
        add_vec(0, 1, 16'h0102, 16'h2222, 0, 0, 16'h0, 4'b0001, 0);
        add_vec(0, 1, 16'h0104, 16'h3333, 0, 0, 16'h0, 4'b0011, 0);
        add_vec(0, 1, 16'h0106, 16'h4444, 0, 0, 16'h0, 4'b0111, 0);
        add_vec(1, 0, 16'h0100, 16'h0000, 0, 0, 16'h0, 4'b1110, 0);
        add_vec(1, 0, 16'h0102, 16'h0000, 0, 0, 16'h0, 4'b1101, 0);
        add_vec(1, 0, 16'h0104, 16'h0000, 0, 1, 16'h1111, 4'b1011, 0);
        add_vec(1, 0, 16'h0106, 16'h0000, 0, 1, 16'h2222, 4'b0111, 0);
        idle(1, 16'h3333, 4'b1110, 0);
        idle(1, 16'h4444, 4'b1100, 0);
        idle(0, 16'h0, 4'b1000, 0);
        idle(0, 16'h0, 4'b0000, 0);
        // illegal requests: rd&wr, then odd address
        add_vec(1, 1, 16'h0020, 16'hFFFF, 0, 0, 16'h0, 4'b0000, 0);
        add_vec(0, 1, 16'h0021, 16'hBEEF, 0, 0, 16'h0, 4'b0000, 1);
        idle(0, 16'h0, 4'b0000, 1);
        idle(0, 16'h0, 4'b0000, 0);
        add_vec(1, 0, 16'h0020, 16'h0000, 0, 0, 16'h0, 4'b0000, 0);
        idle(0, 16'h0, 4'b0001, 0);
        idle(1, 16'h0000, 4'b0001, 0);
        idle(0, 16'h0, 4'b0001, 0);
        idle(0, 16'h0, 4'b0000, 0);
        // banks 0,1,0: third request stalls until bank 0 frees
        add_vec(1, 0, 16'h0100, 16'h0000, 0, 0, 16'h0, 4'b0000, 0);
        add_vec(1, 0, 16'h0102, 16'h0000, 0, 0, 16'h0, 4'b0001, 0);
        add_vec(1, 0, 16'h0010, 16'h0000, 1, 1, 16'h1111, 4'b0011, 0);
        add_vec(1, 0, 16'h0010, 16'h0000, 1, 1, 16'h2222, 4'b0011, 0);
        add_vec(1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0, 4'b0010, 0);
        idle(0, 16'h0, 4'b0001, 0);
        idle(1, 16'hA5A5, 4'b0001, 0);
        idle(0, 16'h0, 4'b0001, 0);
        idle(0, 16'h0, 4'b0000, 0);
        // high address bits alias
        add_vec(1, 0, 16'h8810, 16'h0000, 0, 0, 16'h0, 4'b0000, 0);
        idle(0, 16'h0, 4'b0001, 0);
        idle(1, 16'hA5A5, 4'b0001, 0);
        idle(0, 16'h0, 4'b0001, 0);
        idle(0, 16'h0, 4'b0000, 0);
        // illegal request to a busy bank: err, not stall
        add_vec(1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0, 4'b0000, 0);
        add_vec(1, 1, 16'h0010, 16'h0000, 0, 0, 16'h0, 4'b0001, 0);
        idle(1, 16'hA5A5, 4'b0001, 1);
        idle(0, 16'h0, 4'b0001, 0);
        idle(0, 16'h0, 4'b0000, 0);

        rst     = 1'b1;
        rd      = 1'b0;
        wr      = 1'b0;
        addr    = 16'h0;
        data_in = 16'h0;
        #12 rst = 1'b0;

        for (int i = 0; i < nvec; i++) begin
            @(posedge clk);
            #1;
            rd      = vecs[i].rd;
            wr      = vecs[i].wr;
            addr    = vecs[i].addr;
            data_in = vecs[i].din;
            @(negedge clk);
            chk($sformatf("v%0d stall", i), stall, vecs[i].stall);
            chk($sformatf("v%0d data_valid", i), data_valid, vecs[i].valid);
            chk($sformatf("v%0d data_out", i), data_out, vecs[i].dout);
            chk($sformatf("v%0d busy", i), busy, vecs[i].busy);
            chk($sformatf("v%0d err", i), err, vecs[i].err);
        end

        // asynchronous reset in the cycle after a read is accepted
        @(posedge clk);
        #1;
        rd   = 1'b1;
        addr = 16'h0010;
        @(posedge clk);
        #1;
        rd = 1'b0;
        #1;
        chk("pre_rst busy", busy, 4'b0001);
        rst = 1'b1;
        #1;
        chk("mid_rst busy", busy, 4'b0000);
        chk("mid_rst data_valid", data_valid, 1'b0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #4;
        chk("post_rst data_valid", data_valid, 1'b0);
        chk("post_rst data_out", data_out, 16'h0000);
        chk("post_rst busy", busy, 4'b0000);

        @(posedge clk);
        #1;
        rd   = 1'b1;
        addr = 16'h0010;
        @(posedge clk);
        #1;
        rd = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("reread data_valid", data_valid, 1'b1);
        chk("reread data_out", data_out, 16'h0000);
        @(negedge clk);
        chk("reread valid_pulse", data_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/four_bank_mem.md
Name: four_bank_mem

Overview:
- Banked main-memory model that sits directly downstream of the cache controller FSM and services its mem_rd/mem_wr requests.
- Memory is word-addressed and interleaved over four banks by addr[2:1].
- Each accepted access occupies its bank for BANK_BUSY cycles. Read data returns with a fixed two-cycle latency.
- This lets the controller stream four consecutive line words back-to-back, one per bank, with no stall.

Parameters:
- DEPTH_W, 8, log2 of words per bank. Bank row index is addr[DEPTH_W+2:3].
- BANK_BUSY, 4, cycles a bank is occupied per access, counting the accept cycle. Legal range 2..8.
- DATA_W, 16, data word width.

Ports:
- clk  in  1  system clock. All state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- addr  in  16  byte address. Bit 0 must be 0.
- data_in  in  DATA_W  write data.
- wr  in  1  write request.
- rd  in  1  read request.
- data_out  out  DATA_W  read data. Valid only while data_valid=1, otherwise 0.
- data_valid  out  1  one-cycle pulse marking returned read data.
- stall  out  1  combinational. The request is not accepted this cycle because the target bank is busy.
- busy  out  4  per-bank busy flags, registered.
- err  out  1  registered. Pulses for one cycle after an illegal request.

Behaviour:
- Reset (async, rst=1):
  - All busy counters, the read pipeline, data_valid and err clear to 0. busy=4'b0000, data_out=0.
  - Array contents are zeroed. This is a simulation model; the array is never synthesised as SRAM.
  - A reset mid-operation discards in-flight reads; no data_valid follows.
- Request definitions:
  - req = rd^wr.
  - bank = addr[2:1].
  - stall = req & busy[bank].
  - Request is accepted in cycle t when req & ~busy[bank] & ~illegal.
- Illegal requests:
  - illegal = (rd&wr) | (req & addr[0]).
  - An illegal request is never accepted and changes no state except err. err=1 in cycle t+1.
  - err takes priority over stall: stall is also 0 when illegal.
- Write: on acceptance, the array row is written at the edge ending cycle t.
- Read:
  - On acceptance, the row is read at the edge ending t.
  - Data passes through one more register stage.
  - data_out and data_valid=1 appear in cycle t+2 exactly, independent of later requests or stalls.
- Busy counters (one 3-bit counter per bank):
  - On acceptance, the counter loads BANK_BUSY-1. busy[b]=(cnt!=0).
  - Counters decrement by 1 per cycle while non-zero.
  - Bank b is busy in cycles t+1..t+BANK_BUSY-1 and can accept again in cycle t+BANK_BUSY.
  - Load and decrement of the same bank cannot coincide, because acceptance requires cnt==0.
- Throughput:
  - Accesses to distinct banks in consecutive cycles all accept. One access per cycle maximum.
  - A four-word line at offsets 0,2,4,6 issues in 4 consecutive cycles with no stall.
  - Read data returns in cycles t+2..t+5.
- Read-after-write to the same row: the read cannot accept before t+BANK_BUSY, so it always returns the new data. No bypass is required.
- Address bits 15..DEPTH_W+3 are ignored (aliasing). This is legal, with no err.
- A stalled request is not queued. The requester must hold it until stall=0.
- No state machine beyond the per-bank counters and the 2-stage valid/data pipeline.

Decomposition:
- Shared package holds: NUM_BANKS=4, BANK_SEL_LSB=1, WORD_OFFSET_LSB=3, and the default BANK_BUSY/DEPTH_W constants used by the cache controller and this block.
- One natural sub-module, mem_bank: one bank array plus its busy counter.
  - Inputs: clk, rst, en, wr, row, data_in.
  - Outputs: rdata, busy.
  - Instantiated 4 times. The top holds decode, error logic, read mux and the output pipeline.

Test Plan:
- Reset release, then idle 5 cycles -> busy=0000, data_valid=0, err=0, stall=0, data_out=0.
- Write 16'hA5A5 to addr 16'h0010 in cycle 1; read 16'h0010 in cycles 2..4 -> stall=1 in cycles 2..4, accepted cycle 5, data_out=16'hA5A5 with data_valid=1 in cycle 7.
- Write 16'h1111/2222/3333/4444 to addrs 0x0100/0x0102/0x0104/0x0106 in 4 consecutive cycles, then read the same four at least BANK_BUSY cycles after each write -> no stall on either burst; data returns 1111..4444 in 4 consecutive cycles, each 2 cycles after its request.
- rd=wr=1 at addr 0x0020, then wr=1 at odd addr 0x0021 -> err pulses the cycle after each; busy unchanged; a subsequent read of 0x0020 and 0x0021's aligned word returns 0.
- Read accepted at cycle t, rst asserted asynchronously mid-cycle t+1 -> busy=0000 immediately, no data_valid at t+2, a later read of a previously written address returns 0.
- Back-to-back accesses to banks 0,1,0: read 0x0000, read 0x0002, read 0x0008 -> third request stalls until cycle t+BANK_BUSY=t+4 relative to the first, then accepts; busy[0] pattern 0,1,1,1,0.
